// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with load extraction, writeback and ID bypass
//
// Purpose:
//   Registers the MEM-stage result, extracts and extends load data, drives the
//   register file write port and forwards the value being written into the
//   ID-stage operands (the register file returns stale data on same-cycle reads).
//   Also flags misaligned loads and counts retired instructions.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   stall, flush         hold WB contents / load a bubble (flush wins)
//   mem_*                MEM-stage instruction fields captured into WB
//   ReadRegisters1/2     ID-stage source register indices
//   RegFileData1/2       raw register file read data
//   RegWrite, WriteRegister, WriteData   register file write port
//   ReadData1/2          bypassed operands to ID
//   misalign_err         WB holds a misaligned load
//   retire_count         retired instruction count (wraps)

module wb_stage #(
  parameter int REG_AW     = 5,
  parameter int COUNT_W    = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic               mem_RegWrite,
  input  logic               mem_MemtoReg,
  input  logic [2:0]         mem_LoadType,
  input  logic [REG_AW-1:0]  mem_WriteRegister,
  input  logic [31:0]        mem_ALUResult,
  input  logic [31:0]        mem_ReadData,
  input  logic [REG_AW-1:0]  ReadRegisters1,
  input  logic [REG_AW-1:0]  ReadRegisters2,
  input  logic [31:0]        RegFileData1,
  input  logic [31:0]        RegFileData2,
  output logic               RegWrite,
  output logic [REG_AW-1:0]  WriteRegister,
  output logic [31:0]        WriteData,
  output logic [31:0]        ReadData1,
  output logic [31:0]        ReadData2,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] retire_count
);

  localparam logic BE = (BIG_ENDIAN != 0);

  logic              wbValid;
  logic              wbRegWrite;
  logic              wbMemtoReg;
  logic [2:0]        wbLoadType;
  logic [REG_AW-1:0] wbWriteRegister;
  logic [31:0]       wbALUResult;
  logic [31:0]       wbReadData;
  logic [COUNT_W-1:0] retireCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      wbValid         <= 1'b0;
      wbRegWrite      <= 1'b0;
      wbMemtoReg      <= 1'b0;
      wbLoadType      <= 3'd0;
      wbWriteRegister <= '0;
      wbALUResult     <= 32'd0;
      wbReadData      <= 32'd0;
      retireCount     <= '0;
    end else begin
      // An instruction retires on the edge where it leaves WB unstalled.
      if (wbValid && !stall) begin
        retireCount <= retireCount + COUNT_W'(1);
      end
      if (flush) begin
        // Fields of a bubble are irrelevant; zero them so WB outputs stay quiet.
        wbValid         <= 1'b0;
        wbRegWrite      <= 1'b0;
        wbMemtoReg      <= 1'b0;
        wbLoadType      <= 3'd0;
        wbWriteRegister <= '0;
        wbALUResult     <= 32'd0;
        wbReadData      <= 32'd0;
      end else if (!stall) begin
        wbValid         <= mem_valid;
        wbRegWrite      <= mem_RegWrite;
        wbMemtoReg      <= mem_MemtoReg;
        wbLoadType      <= mem_LoadType;
        wbWriteRegister <= mem_WriteRegister;
        wbALUResult     <= mem_ALUResult;
        wbReadData      <= mem_ReadData;
      end
    end
  end

  logic [1:0]  off;
  logic [1:0]  byteSel;
  logic        halfSel;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;
  logic        isWord;
  logic        isHalf;
  logic        misalign;

  assign off     = wbALUResult[1:0];
  // Big-endian memory places byte 0 in the top lane, so mirror the lane index.
  assign byteSel = off ^ {2{BE}};
  assign halfSel = off[1] ^ BE;

  always_comb begin
    loadByte = 8'd0;
    case (byteSel)
      2'd0: loadByte = wbReadData[7:0];
      2'd1: loadByte = wbReadData[15:8];
      2'd2: loadByte = wbReadData[23:16];
      2'd3: loadByte = wbReadData[31:24];
      default: loadByte = 8'd0;
    endcase
  end

  assign loadHalf = halfSel ? wbReadData[31:16] : wbReadData[15:0];

  always_comb begin
    loadData = wbReadData;
    case (wbLoadType)
      3'b001:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b010:  loadData = {24'd0, loadByte};
      3'b011:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {16'd0, loadHalf};
      default: loadData = wbReadData;
    endcase
  end

  // Unused encodings behave as lw, including for alignment checking.
  assign isHalf = (wbLoadType == 3'b011) || (wbLoadType == 3'b100);
  assign isWord = !((wbLoadType == 3'b001) || (wbLoadType == 3'b010) || isHalf);

  assign misalign = wbValid && wbMemtoReg &&
                    ((isWord && (off != 2'd0)) || (isHalf && off[0]));

  assign WriteData     = wbMemtoReg ? loadData : wbALUResult;
  assign WriteRegister = wbWriteRegister;
  assign RegWrite      = wbValid && wbRegWrite && (wbWriteRegister != '0) && !misalign;
  assign misalign_err  = misalign;
  assign retire_count  = retireCount;

  always_comb begin
    ReadData1 = RegFileData1;
    if (ReadRegisters1 == '0) begin
      ReadData1 = 32'd0;
    end else if (RegWrite && (WriteRegister == ReadRegisters1)) begin
      ReadData1 = WriteData;
    end
  end

  always_comb begin
    ReadData2 = RegFileData2;
    if (ReadRegisters2 == '0) begin
      ReadData2 = 32'd0;
    end else if (RegWrite && (WriteRegister == ReadRegisters2)) begin
      ReadData2 = WriteData;
    end
  end

endmodule
